mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALU-op code that the downstream ALU-control decoder expands with funct.
- Also drives every mux select and write enable for PC, IR, register file and memory, and stalls on a memory ready handshake.

Parameters:
- none (opcode and state encodings are fixed constants in the shared package)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  write-data select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination select: 0=rt, 1=rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B select: 00=B reg, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=use funct
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Moore FSM. State register clocked on rising clk. reset asynchronously forces FETCH.
- While reset=1, every strobe output is 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op. Mux selects are 0 and state=0.
- Outputs decode combinationally from state, plus mem_ready where noted. Unlisted outputs are 0 in each state.
- FETCH (0): mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are 1 only when mem_ready=1.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 0x00 -> EXEC
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX (only with the optional feature)
  - else -> FETCH, with illegal_op=1 and instr_done=1
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if opcode=0x23, else MEMWR.
- MEMRD (3): mem_read=1, iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Then FETCH.
- MEMWR (5): mem_write=1, iord=1. Holds until mem_ready.
  - instr_done=1 only in the cycle mem_ready=1; then FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Then FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Then FETCH.
- JUMP (9): pc_write=1, pc_source=10, instr_done=1. Then FETCH.
- Unused encodings, including 10/11 when the feature is compiled out: all strobes 0, next state FETCH.
- Latency with mem_ready held at 1:
  - R-type 4 cycles
  - lw 5 cycles
  - sw 4 cycles
  - beq 3 cycles
  - j 3 cycles
  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is sampled in DECODE and MEMADR only; changes elsewhere are ignored.
- Reset mid-instruction aborts with no partial writes and restarts in FETCH.

Optional Feature:
- Macro: MIPS_MC_CTRL_ADDI_EN.
- Defined: opcode 0x08 goes DECODE -> ADDIEX -> ADDIWB -> FETCH.
  - ADDIEX (10): alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB (11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - addi latency is 4 cycles.
- Undefined: 0x08 is illegal (illegal_op pulse, back to FETCH). States 10/11 are unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings (0-11)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALU-op codes: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - alu_src_b and pc_source select codes
- One sub-module, mips_mc_ctrl_outdec: purely combinational state+mem_ready -> output decoder. The top keeps the state register and next-state logic.

Test Plan:
- R-type (opcode 0x00), mem_ready=1:
  - states 0,1,6,7,0
  - alu_op=10 in EXEC
  - reg_write=1 and reg_dst=1 only in ALUWB
  - instr_done exactly once, on cycle 4
- lw (0x23) with mem_ready low for 2 cycles in FETCH and 3 in MEMRD:
  - total 10 cycles
  - ir_write a single pulse, coincident with mem_ready
  - reg_write with mem_to_reg=1 in MEMWB
- sw (0x2B) then beq (0x04):
  - mem_write=1 with iord=1 until mem_ready
  - no reg_write
  - beq takes 3 cycles with alu_op=01, pc_write_cond=1, pc_source=01
- j (0x02): 3 cycles; pc_write=1 and pc_source=10 in JUMP.
- Opcode 0x08 with and without MIPS_MC_CTRL_ADDI_EN:
  - enabled: 4 cycles, reg_write with reg_dst=0
  - disabled: illegal_op pulse in DECODE, back to FETCH
- Illegal opcode 0x3F: single illegal_op pulse, next state FETCH.
- reset asserted asynchronously mid-MEMWR with mem_write=1: mem_write drops immediately; state=0 after reset release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// The optional addi path is enabled by defining MIPS_MC_CTRL_ADDI_EN.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_BREG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MIPS_MC_CTRL_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_outdec.sv
// Combinational output decoder: state (+ mem_ready, + opcode legality in DECODE) to controls.
// Reset forces every control low so an async reset stops writes in the same cycle.
module mips_mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_BREG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BRANCH;
                    if (!op_supported(opcode)) begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
`ifdef MIPS_MC_CTRL_ADDI_EN
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: state register and next-state logic.
// Define MIPS_MC_CTRL_ADDI_EN to add the ADDIEX/ADDIWB path for opcode 0x08.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t cur_state, next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MIPS_MC_CTRL_ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
`ifdef MIPS_MC_CTRL_ADDI_EN
            S_ADDIEX: next_state = S_ADDIWB;
`endif
            default:  next_state = S_FETCH;
        endcase
    end

    assign state = cur_state;

    mips_mc_ctrl_outdec u_outdec (
        .reset         (reset),
        .state         (cur_state),
        .mem_ready     (mem_ready),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed latency/handshake cases plus random instruction
// streams checked against an instruction-level phase model.
module tb_mips_mc_ctrl;

`ifdef MIPS_MC_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mips_mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    wire [17:0] ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                        alu_op, pc_source, instr_done, illegal_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
               (op == 6'h02) || (ADDI_EN && op == 6'h08);
    endfunction

    // Required control word for a phase, straight from the per-state output table.
    function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        logic dn = 0, il = 0;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  begin sb = 2'b11; if (!legal(op)) begin il = 1; dn = 1; end end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; dn = 1; end
            5:  begin mwr = 1; io = 1; dn = mr; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; dn = 1; end
            8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
            9:  begin pw = 1; ps = 2'b10; dn = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, dn, il};
    endfunction

    // Run one instruction from FETCH; bit k of low_mask holds mem_ready low on cycle k+1.
    task automatic run_instr(input logic [5:0] op, input logic [31:0] low_mask,
                             output int lat, output int ir_cnt, output int rw_cnt,
                             output int ill_cnt, output logic rw_dst, output logic rw_m2r);
        lat = 99; ir_cnt = 0; rw_cnt = 0; ill_cnt = 0; rw_dst = 0; rw_m2r = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            mem_ready = !low_mask[cyc-1];
            opcode    = op;
            @(negedge clk);
            if (ir_write) ir_cnt++;
            if (illegal_op) ill_cnt++;
            if (reg_write) begin rw_cnt++; rw_dst = reg_dst; rw_m2r = mem_to_reg; end
            if (instr_done) begin lat = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("boundary_state", 32'(state), 0);
    endtask

    int lat, irc, rwc, ilc;
    logic rdst, rm2r;
    int ph_st[$];
    bit ph_wait[$];
    logic [5:0] cur_op;
    logic [5:0] op_tab [8];

    task automatic new_instr();
        int k;
        op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h00};
        k = $urandom_range(0, 7);
        cur_op = (k == 7) ? 6'($urandom_range(0, 63)) : op_tab[k];
        ph_st = {0, 1}; ph_wait = {1'b1, 1'b0};
        if (legal(cur_op)) begin
            case (cur_op)
                6'h00: begin ph_st.push_back(6); ph_wait.push_back(0);
                             ph_st.push_back(7); ph_wait.push_back(0); end
                6'h23: begin ph_st.push_back(2); ph_wait.push_back(0);
                             ph_st.push_back(3); ph_wait.push_back(1);
                             ph_st.push_back(4); ph_wait.push_back(0); end
                6'h2B: begin ph_st.push_back(2); ph_wait.push_back(0);
                             ph_st.push_back(5); ph_wait.push_back(1); end
                6'h04: begin ph_st.push_back(8); ph_wait.push_back(0); end
                6'h02: begin ph_st.push_back(9); ph_wait.push_back(0); end
                default: begin ph_st.push_back(10); ph_wait.push_back(0);
                               ph_st.push_back(11); ph_wait.push_back(0); end
            endcase
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
        #12;
        chk("reset_state", 32'(state), 0);
        chk("reset_ctrl", 32'(ctrl), 0);
        mem_ready = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_state", 32'(state), 0);

        run_instr(6'h00, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("rtype_lat", 32'(lat), 4);
        chk("rtype_rw", 32'(rwc), 1);
        chk("rtype_rdst", 32'(rdst), 1);
        run_instr(6'h23, 32'b1110_0011, lat, irc, rwc, ilc, rdst, rm2r);
        chk("lw_stall_lat", 32'(lat), 10);
        chk("lw_ir_pulses", 32'(irc), 1);
        chk("lw_m2r", 32'(rm2r), 1);
        run_instr(6'h23, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("lw_lat", 32'(lat), 5);
        run_instr(6'h2B, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("sw_lat", 32'(lat), 4);
        chk("sw_no_rw", 32'(rwc), 0);
        run_instr(6'h04, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("beq_lat", 32'(lat), 3);
        run_instr(6'h02, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("j_lat", 32'(lat), 3);
        run_instr(6'h08, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("addi_lat", 32'(lat), ADDI_EN ? 4 : 2);
        chk("addi_ill", 32'(ilc), ADDI_EN ? 0 : 1);
        chk("addi_rw", 32'(rwc), ADDI_EN ? 1 : 0);
        run_instr(6'h3F, 32'h0, lat, irc, rwc, ilc, rdst, rm2r);
        chk("ill_lat", 32'(lat), 2);
        chk("ill_pulses", 32'(ilc), 1);

        // Random instruction stream against the phase model.
        new_instr();
        for (int c = 0; c < 600; c++) begin
            int st;
            st = ph_st[0];
            opcode = (st == 1 || st == 2) ? cur_op : 6'($urandom_range(0, 63));
            mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rnd_state", 32'(state), 32'(st));
            chk("rnd_ctrl", 32'(ctrl), 32'(exp_ctrl(st, mem_ready, cur_op)));
            if (!(ph_wait[0] && !mem_ready)) begin
                void'(ph_st.pop_front());
                void'(ph_wait.pop_front());
            end
            if (ph_st.size() == 0) new_instr();
            @(posedge clk); #1;
        end
        // Drain to an instruction boundary with mem_ready high.
        for (int c = 0; c < 10 && !(ph_st.size() == 2 && ph_st[0] == 0); c++) begin
            opcode = cur_op; mem_ready = 1'b1;
            @(negedge clk);
            void'(ph_st.pop_front()); void'(ph_wait.pop_front());
            if (ph_st.size() == 0) new_instr();
            @(posedge clk); #1;
        end
        chk("drain_state", 32'(state), 0);

        // Async reset in the middle of a stalled store.
        opcode = 6'h2B; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("sw_wait_state", 32'(state), 5);
        chk("sw_wait_mw", 32'(mem_write), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mw_drop", 32'(mem_write), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_ctrl", 32'(ctrl), 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_state", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
